// File: rtl/vram_write_buffer.sv
// VRAM port owner: display reads take the port whenever the display is active; CPU pixel
// writes are queued in a FIFO and drained into VRAM during blanking.
module vram_write_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 20,
    parameter int unsigned DW    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DW-1:0]              wr_data,
    input  logic                       disp_active,
    input  logic [AW-1:0]              disp_addr,
    output logic [DW-1:0]              disp_data,
    output logic                       disp_valid,
    output logic [AW-1:0]              ram_addr,
    output logic                       ram_we,
    output logic [DW-1:0]              ram_wdata,
    input  logic [DW-1:0]              ram_rdata,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       fifo_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = AW + DW;

    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          ram_we_q, ram_we_d;
    logic [2:0]    act_q, act_d;
    logic [DW-1:0] disp_data_q, disp_data_d;

    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign wr_ready   = (level_q != LW'(DEPTH));
    assign fifo_empty = (level_q == '0);
    assign push       = wr_valid & wr_ready;
    assign pop        = ~disp_active & ~fifo_empty;
    assign head       = mem_q[rd_ptr_q];

    // Next-state: FIFO bookkeeping, RAM port arbitration and display delay line.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        act_d       = {act_q[1:0], disp_active};
        disp_data_d = act_q[1] ? ram_rdata : '0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (disp_active) begin
            ram_addr_d = disp_addr;
        end else if (pop) begin
            ram_addr_d  = head[EW-1:DW];
            ram_wdata_d = head[DW-1:0];
            ram_we_d    = 1'b1;
        end

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            ram_addr_d  = '0;
            ram_wdata_d = '0;
            ram_we_d    = 1'b0;
            act_d       = '0;
            disp_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            act_q       <= '0;
            disp_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            act_q       <= act_d;
            disp_data_q <= disp_data_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_addr, wr_data};
        end
    end

    assign fifo_level = level_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = act_q[2];

endmodule

// File: tb/tb_vram_write_buffer.sv
// Directed bench for vram_write_buffer with a behavioural VRAM (addr n reads n[11:0] until written).
module tb_vram_write_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 20;
    localparam int unsigned DW    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          disp_active;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [4:0]    fifo_level;
    logic          fifo_empty;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] vram [logic [AW-1:0]];

    always #5 clk = ~clk;

    vram_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .disp_active(disp_active), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty)
    );

    // Synchronous single-port VRAM, read-before-write.
    always @(posedge clk) begin
        ram_rdata <= vram.exists(ram_addr) ? vram[ram_addr] : ram_addr[DW-1:0];
        if (ram_we) vram[ram_addr] = ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        disp_active = 1'b0; disp_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step(); step();
        rst = 1'b0;

        // 1: reset mid-drain with level 5
        disp_active = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(20'h40 + i); wr_data = DW'(i);
            step();
        end
        wr_valid = 1'b0; disp_active = 1'b0;
        step();
        chk("t1_level_pre", 32'(fifo_level), 32'd5);
        chk("t1_we_pre", 32'(ram_we), 32'd1);
        do_reset();
        #0;
        chk("t1_level", 32'(fifo_level), 32'd0);
        chk("t1_we", 32'(ram_we), 32'd0);
        chk("t1_valid", 32'(disp_valid), 32'd0);
        chk("t1_ready", 32'(wr_ready), 32'd1);
        chk("t1_empty", 32'(fifo_empty), 32'd1);
        chk("t1_addr", 32'(ram_addr), 32'd0);

        // 2: blank drain of three writes
        idle_inputs();
        wr_valid = 1'b1; wr_addr = 20'h10; wr_data = 12'hF00;
        step();
        chk("t2_we_e1", 32'(ram_we), 32'd0);
        wr_addr = 20'h11; wr_data = 12'h0F0;
        step();
        chk("t2_we_e2", 32'(ram_we), 32'd1);
        chk("t2_addr_e2", 32'(ram_addr), 32'h10);
        chk("t2_data_e2", 32'(ram_wdata), 32'hF00);
        wr_addr = 20'h12; wr_data = 12'h00F;
        step();
        wr_valid = 1'b0;
        chk("t2_we_e3", 32'(ram_we), 32'd1);
        chk("t2_addr_e3", 32'(ram_addr), 32'h11);
        chk("t2_data_e3", 32'(ram_wdata), 32'h0F0);
        step();
        chk("t2_we_e4", 32'(ram_we), 32'd1);
        chk("t2_addr_e4", 32'(ram_addr), 32'h12);
        chk("t2_data_e4", 32'(ram_wdata), 32'h00F);
        step();
        chk("t2_we_e5", 32'(ram_we), 32'd0);
        chk("t2_level", 32'(fifo_level), 32'd0);

        // 3: display priority for 640 cycles with 4 queued writes
        disp_active = 1'b1;
        for (int k = 0; k < 640; k++) begin
            disp_addr = AW'(20'h8000 + k);
            wr_valid  = (k < 4);
            wr_addr   = AW'(20'h200 + k);
            wr_data   = DW'(12'h500 + k);
            step();
            chk("t3_we_active", 32'(ram_we), 32'd0);
            chk("t3_addr_follow", 32'(ram_addr), 32'(20'h8000 + k));
        end
        wr_valid = 1'b0;
        chk("t3_level", 32'(fifo_level), 32'd4);
        disp_active = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_drain_we", 32'(ram_we), 32'd1);
            chk("t3_drain_addr", 32'(ram_addr), 32'(20'h200 + k));
            chk("t3_drain_data", 32'(ram_wdata), 32'(12'h500 + k));
        end
        step();
        chk("t3_we_done", 32'(ram_we), 32'd0);
        chk("t3_empty", 32'(fifo_empty), 32'd1);

        // 4: full FIFO holds the 17th write until blanking frees an entry
        disp_active = 1'b1; disp_addr = 20'h1;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(20'h300 + i); wr_data = DW'(12'h100 + i);
            step();
        end
        chk("t4_level_full", 32'(fifo_level), 32'd16);
        chk("t4_ready_full", 32'(wr_ready), 32'd0);
        wr_addr = 20'h3FF; wr_data = 12'hABC;
        step(); step(); step();
        chk("t4_level_held", 32'(fifo_level), 32'd16);
        chk("t4_ready_held", 32'(wr_ready), 32'd0);
        disp_active = 1'b0;
        step();
        chk("t4_e1_addr", 32'(ram_addr), 32'h300);
        chk("t4_e1_level", 32'(fifo_level), 32'd15);
        chk("t4_e1_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        chk("t4_e2_addr", 32'(ram_addr), 32'h301);
        chk("t4_e2_level", 32'(fifo_level), 32'd15);
        for (int i = 2; i < 17; i++) begin
            step();
            chk("t4_drain_we", 32'(ram_we), 32'd1);
            chk("t4_drain_addr", 32'(ram_addr), (i == 16) ? 32'h3FF : 32'(20'h300 + i));
            chk("t4_drain_data", 32'(ram_wdata), (i == 16) ? 32'hABC : 32'(12'h100 + i));
        end
        step();
        chk("t4_empty", 32'(fifo_empty), 32'd1);

        // 5: display latency of three cycles
        disp_active = 1'b1; disp_addr = 20'h123;
        step();
        disp_active = 1'b0; disp_addr = '0;
        chk("t5_valid_t1", 32'(disp_valid), 32'd0);
        chk("t5_data_t1", 32'(disp_data), 32'd0);
        step();
        chk("t5_valid_t2", 32'(disp_valid), 32'd0);
        chk("t5_data_t2", 32'(disp_data), 32'd0);
        step();
        chk("t5_valid_t3", 32'(disp_valid), 32'd1);
        chk("t5_data_t3", 32'(disp_data), 32'h123);
        step();
        chk("t5_valid_t4", 32'(disp_valid), 32'd0);
        chk("t5_data_t4", 32'(disp_data), 32'd0);

        // 6: flush with level 7 and a simultaneous push
        disp_active = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1; wr_addr = AW'(20'h700 + i); wr_data = DW'(i);
            step();
        end
        chk("t6_level_pre", 32'(fifo_level), 32'd7);
        flush = 1'b1; wr_addr = 20'h7FF;
        step();
        flush = 1'b0; wr_valid = 1'b0; disp_active = 1'b0;
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_ready", 32'(wr_ready), 32'd1);
        chk("t6_empty", 32'(fifo_empty), 32'd1);
        chk("t6_addr", 32'(ram_addr), 32'd0);
        step();
        chk("t6_level_after", 32'(fifo_level), 32'd0);
        chk("t6_we_after", 32'(ram_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
